seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner_if.sv | 27 ++
 rtl/seven_seg_scanner.sv | 133 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Display-side bus of the multiplexed hex scanner: CPU display register
// inputs (nibbles, decimal points, load strobe, enable, brightness) and the
// board-facing AN/SEG pins plus status.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 3
);
  logic [4*NUM_DIGITS-1:0] dig;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    load;
  logic                    en;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    pending;
  logic                    frame_tick;
  logic [NUM_DIGITS-1:0]   AN;
  logic [7:0]              SEG;

  modport master (
    output dig, dp_mask, load, en, brightness,
    input  pending, frame_tick, AN, SEG
  );

  modport slave (
    input  dig, dp_mask, load, en, brightness,
    output pending, frame_tick, AN, SEG
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode hex display scanner.
// - A prescaler divides each digit slot into SCAN_DIV cycles; digits are
//   scanned 0..NUM_DIGITS-1, one frame being a full pass.
// - Loaded values sit in a shadow register and move to the display register
//   only on a frame boundary, so a frame never mixes old and new digits.
// - Brightness gates the digit for the first (brightness+1) of 2**BRIGHT_W
//   equal phases of each slot.
// Optional: define SEVEN_SEG_LZ_BLANK_EN for leading-zero blanking.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 5000,
  parameter int BRIGHT_W   = 3
) (
  input logic              clk,
  input logic              rst,
  seven_seg_scanner_if.slave bus
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PH_LEN = SCAN_DIV >> BRIGHT_W;

  // Active-low segment pattern g..a for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] shd_dig_q, shd_dig_d, dsp_dig_q, dsp_dig_d;
  logic [NUM_DIGITS-1:0]      shd_dp_q, shd_dp_d, dsp_dp_q, dsp_dp_d;
  logic                       pend_q, pend_d;
  logic                       tick_q, tick_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic [7:0]                 seg_q, seg_d;

  logic                       slot_end, frame_bnd, lit;
  logic [BRIGHT_W-1:0]        phase;
  logic [IDX_W-1:0]           top_nz;
  logic [6:0]                 seg7;

  // Prescaler, digit index and the shadow-to-display handoff.
  always_comb begin
    slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_bnd = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = frame_bnd ? '0 : idx_q + 1'b1;
    tick_d    = frame_bnd;

    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    dsp_dig_d = dsp_dig_q;
    dsp_dp_d  = dsp_dp_q;
    pend_d    = pend_q;
    if (bus.load) begin
      shd_dig_d = bus.dig;
      shd_dp_d  = bus.dp_mask;
      // A load landing on the boundary bypasses the shadow entirely.
      if (frame_bnd) begin
        dsp_dig_d = bus.dig;
        dsp_dp_d  = bus.dp_mask;
        pend_d    = 1'b0;
      end else begin
        pend_d    = 1'b1;
      end
    end else if (frame_bnd && pend_q) begin
      dsp_dig_d = shd_dig_q;
      dsp_dp_d  = shd_dp_q;
      pend_d    = 1'b0;
    end
  end

  // Next pin values from the current slot position and display register.
  always_comb begin
    phase  = BRIGHT_W'(int'(cnt_q) / PH_LEN);
    lit    = bus.en && (phase <= bus.brightness);
    seg7   = hex7(dsp_dig_q[idx_q]);
    top_nz = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dsp_dig_q[i] != 4'h0) top_nz = IDX_W'(i);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Digit 0 can never exceed top_nz, so an all-zero value still shows "0".
    if (idx_q > top_nz) seg7 = 7'h7F;
`endif
    an_d  = '1;
    seg_d = 8'hFF;
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = {~dsp_dp_q[idx_q], seg7};
    end
  end

  // State and output registers; reset discards any pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      dsp_dig_q <= '0;
      dsp_dp_q  <= '0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      dsp_dig_q <= dsp_dig_d;
      dsp_dp_q  <= dsp_dp_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.pending    = pend_q;
  assign bus.frame_tick = tick_q;
  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, 16-cycle slots, 2-bit brightness).
// The reference model works from elapsed cycles since reset: slot position
// and digit follow from modular arithmetic on that count.
module tb_seven_seg_scanner;
  localparam int ND = 4, SD = 16, BW = 2;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();
  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int nvec = 0, nerr = 0;
  int tm;
  logic [3:0] m_dig [ND], m_sdig [ND];
  logic [ND-1:0] m_dp, m_sdp;
  bit m_pend;
  logic [ND-1:0] e_an;
  logic [7:0] e_seg;
  bit e_pend, e_tick;
  logic [7:0] cap_seg [ND];
  int cap_low [ND];
  int cap_bad;

  // Advance one clock: predict the pins after the edge, then take the edge.
  task automatic step();
    int cnt, idx, top;
    bit lit, fb;
    logic [6:0] s7;
    if (rst) begin
      e_an = '1; e_seg = 8'hFF; e_pend = 0; e_tick = 0; tm = 0;
      m_pend = 0; m_dp = '0; m_sdp = '0;
      for (int i = 0; i < ND; i++) begin m_dig[i] = '0; m_sdig[i] = '0; end
    end else begin
      cnt = tm % SD; idx = (tm / SD) % ND;
      lit = bus.en && ((cnt / (SD >> BW)) <= int'(bus.brightness));
      s7 = HEX[m_dig[idx]];
      top = 0;
      for (int i = 0; i < ND; i++) if (m_dig[i] != 0) top = i;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (idx > top) s7 = 7'h7F;
`endif
      e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
      e_seg = lit ? {~m_dp[idx], s7} : 8'hFF;
      fb = (tm % FRAME) == FRAME - 1;
      e_tick = fb;
      if (bus.load) begin
        for (int i = 0; i < ND; i++) m_sdig[i] = bus.dig[4*i +: 4];
        m_sdp = bus.dp_mask;
        if (fb) begin m_dig = m_sdig; m_dp = m_sdp; m_pend = 0; end
        else m_pend = 1;
      end else if (fb && m_pend) begin
        m_dig = m_sdig; m_dp = m_sdp; m_pend = 0;
      end
      e_pend = m_pend;
      tm++;
    end
    @(posedge clk); #1;
  endtask

  // Run n cycles, recording the last SEG seen per digit and AN-low counts.
  task automatic capture(input int n);
    cap_bad = 0;
    for (int i = 0; i < ND; i++) begin cap_seg[i] = 8'hxx; cap_low[i] = 0; end
    for (int k = 0; k < n; k++) begin
      step();
      if ({bus.AN, bus.SEG, bus.pending, bus.frame_tick} !== {e_an, e_seg, e_pend, e_tick})
        cap_bad++;
      for (int i = 0; i < ND; i++)
        if (bus.AN[i] === 1'b0) begin cap_low[i]++; cap_seg[i] = bus.SEG; end
    end
  endtask

  // Step until frame_tick is seen; returns 0 if it never arrives.
  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int k = 0; k < 3 * FRAME && !ok; k++) begin
      step();
      if (bus.frame_tick === 1'b1) ok = 1;
    end
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] dp);
    bus.dig = d; bus.dp_mask = dp; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) step();
    nvec++;
    if ({bus.AN, bus.SEG, bus.pending, bus.frame_tick} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset: AN=%h SEG=%h pend=%b tick=%b, want F FF 0 0",
               bus.AN, bus.SEG, bus.pending, bus.frame_tick);
    end
  endtask

  task automatic test_idle();
    int ticks = 0;
    rst = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      nvec++;
      if ({bus.AN, bus.SEG, bus.pending, bus.frame_tick} !== {e_an, e_seg, e_pend, e_tick}) begin
        nerr++;
        $display("FAIL idle t=%0d: AN=%h SEG=%h pend=%b tick=%b, want %h %h %b %b",
                 tm, bus.AN, bus.SEG, bus.pending, bus.frame_tick, e_an, e_seg, e_pend, e_tick);
      end
      if (bus.frame_tick) ticks++;
      if (bus.AN !== 4'hF) begin
        nvec++;
        if (bus.SEG !== 8'hC0) begin nerr++; $display("FAIL idle_zero: SEG=%h want C0", bus.SEG); end
      end
    end
    nvec++;
    if (ticks !== 2) begin nerr++; $display("FAIL idle_ticks: %0d ticks, want 2", ticks); end
  endtask

  task automatic test_load();
    bit ok = 0;
    int n = $urandom_range(20, 40);
    for (int k = 0; k < n; k++) step();
    load_val(16'h1A2F, 4'b0010);
    for (int k = 0; k < 3 * FRAME && !ok; k++) begin
      nvec++;
      if (bus.pending !== 1'b1) begin nerr++; $display("FAIL load_pending: pend=%b want 1", bus.pending); end
      step();
      if (bus.frame_tick === 1'b1) ok = 1;
    end
    nvec++;
    if (!ok || bus.pending !== 1'b0) begin
      nerr++; $display("FAIL load_commit: tick_seen=%b pend=%b, want 1 0", ok, bus.pending);
    end
    capture(FRAME);
    nvec++;
    if ({cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]} !== 32'hF988248E || cap_bad !== 0) begin
      nerr++;
      $display("FAIL load_digits: %h %h %h %h bad=%0d, want F9 88 24 8E bad=0",
               cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0], cap_bad);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_val(16'h1111, 4'b0000);
    for (int k = 0; k < 3; k++) step();
    load_val(16'h2222, 4'b0000);
    wait_tick(ok);
    capture(FRAME);
    nvec++;
    if (!ok || {cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]} !== 32'hA4A4A4A4 ||
        cap_bad !== 0 || bus.pending !== 1'b0) begin
      nerr++;
      $display("FAIL last_load_wins: tick=%b %h %h %h %h bad=%0d pend=%b, want A4 x4 bad=0 pend=0",
               ok, cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0], cap_bad, bus.pending);
    end
    while ((tm % FRAME) != FRAME - 1) step();
    load_val(16'h3333, 4'b0000);
    nvec++;
    if ({bus.AN, bus.SEG, bus.pending, bus.frame_tick} !== {e_an, e_seg, e_pend, e_tick}) begin
      nerr++; $display("FAIL boundary_load_model: AN=%h SEG=%h pend=%b, want %h %h %b",
                       bus.AN, bus.SEG, bus.pending, e_an, e_seg, e_pend);
    end
    step();
    nvec++;
    if ({bus.AN, bus.SEG, bus.pending} !== {4'hE, 8'hB0, 1'b0}) begin
      nerr++; $display("FAIL boundary_load: AN=%h SEG=%h pend=%b, want E B0 0",
                       bus.AN, bus.SEG, bus.pending);
    end
  endtask

  task automatic test_brightness();
    bus.brightness = 2'd0; step();
    capture(FRAME);
    nvec++;
    if (cap_low[0] !== 4 || cap_low[1] !== 4 || cap_low[2] !== 4 || cap_low[3] !== 4 || cap_bad !== 0) begin
      nerr++; $display("FAIL bright0: on=%0d %0d %0d %0d bad=%0d, want 4 each bad=0",
                       cap_low[0], cap_low[1], cap_low[2], cap_low[3], cap_bad);
    end
    bus.brightness = 2'd2; step();
    capture(FRAME);
    nvec++;
    if (cap_low[0] !== 12 || cap_low[1] !== 12 || cap_low[2] !== 12 || cap_low[3] !== 12 || cap_bad !== 0) begin
      nerr++; $display("FAIL bright2: on=%0d %0d %0d %0d bad=%0d, want 12 each bad=0",
                       cap_low[0], cap_low[1], cap_low[2], cap_low[3], cap_bad);
    end
    bus.en = 1'b0; step();
    for (int k = 0; k < FRAME; k++) begin
      step();
      nvec++;
      if ({bus.AN, bus.SEG} !== {4'hF, 8'hFF}) begin
        nerr++; $display("FAIL en_off: AN=%h SEG=%h, want F FF", bus.AN, bus.SEG);
      end
    end
    bus.en = 1'b1; bus.brightness = 2'd3;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      bus.brightness = 2'($urandom_range(0, 3));
      bus.load = ($urandom_range(0, 19) == 0);
      bus.dig = 16'($urandom);
      bus.dp_mask = 4'($urandom);
      step();
      nvec++;
      if ({bus.AN, bus.SEG, bus.pending, bus.frame_tick} !== {e_an, e_seg, e_pend, e_tick}) begin
        nerr++;
        $display("FAIL random t=%0d: AN=%h SEG=%h pend=%b tick=%b, want %h %h %b %b",
                 tm, bus.AN, bus.SEG, bus.pending, bus.frame_tick, e_an, e_seg, e_pend, e_tick);
      end
    end
    bus.load = 1'b0; bus.en = 1'b1; bus.brightness = 2'd3;
  endtask

  task automatic test_rst_mid();
    while ((tm % FRAME) != 20) step();
    load_val(16'h4567, 4'b1111);
    step(); step();
    nvec++;
    if (bus.pending !== 1'b1) begin nerr++; $display("FAIL rst_pre_pending: pend=%b want 1", bus.pending); end
    rst = 1'b1; step();
    nvec++;
    if ({bus.AN, bus.SEG, bus.pending, bus.frame_tick} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL rst_mid: AN=%h SEG=%h pend=%b tick=%b, want F FF 0 0",
                       bus.AN, bus.SEG, bus.pending, bus.frame_tick);
    end
    rst = 1'b0; step();
    nvec++;
    if ({bus.AN, bus.SEG, bus.pending} !== {4'hE, 8'hC0, 1'b0}) begin
      nerr++; $display("FAIL rst_restart: AN=%h SEG=%h pend=%b, want E C0 0",
                       bus.AN, bus.SEG, bus.pending);
    end
  endtask

  task automatic test_lz();
    bit ok;
    logic [31:0] want;
    load_val(16'h0050, 4'b0000);
    wait_tick(ok);
    capture(FRAME);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    want = 32'hFFFF92C0;
`else
    want = 32'hC0C092C0;
`endif
    nvec++;
    if (!ok || {cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]} !== want || cap_bad !== 0) begin
      nerr++; $display("FAIL lz_0050: %h %h %h %h bad=%0d, want %h bad=0",
                       cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0], cap_bad, want);
    end
    load_val(16'h0000, 4'b0000);
    wait_tick(ok);
    capture(FRAME);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    want = 32'hFFFFFFC0;
`else
    want = 32'hC0C0C0C0;
`endif
    nvec++;
    if (!ok || {cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]} !== want || cap_bad !== 0) begin
      nerr++; $display("FAIL lz_zero: %h %h %h %h bad=%0d, want %h bad=0",
                       cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0], cap_bad, want);
    end
  endtask

  initial begin
    bus.dig = '0; bus.dp_mask = '0; bus.load = 1'b0;
    bus.en = 1'b1; bus.brightness = 2'd3;
    @(posedge clk); #1;
    test_reset();
    test_idle();
    test_load();
    test_back_to_back();
    test_brightness();
    test_random();
    test_rst_mid();
    test_lz();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
